// File: rtl/float_pkg.sv
// float_pkg: shared FSM states, operand classes and IEEE field helpers for the divider
package float_pkg;
    typedef enum logic [2:0] {IDLE, SPECIAL, DIVIDE, ROUND, DONE} state_t;
    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_t;
    // Subnormals (exp==0) are treated as zero.
    function automatic cls_t classify(input logic exp_zero, input logic exp_ones, input logic frac_nz);
        return exp_zero ? ZERO : !exp_ones ? NORM : frac_nz ? NAN : INF;
    endfunction
    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [127:0] qnan(input int exp_w, input int man_w);
        return (((128'd1 << exp_w) - 128'd1) << man_w) | (128'd1 << (man_w - 1));
    endfunction
endpackage

// File: rtl/float_div_step.sv
// float_div_step: one restoring radix-2 division step
module float_div_step #(
    parameter int W = 25
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] next_rem_o,
    output logic         q_bit_o
);
    logic [W:0] trial;
    // Subtract when it does not go negative, then shift the partial remainder up.
    always_comb begin
        trial      = {1'b0, rem_i} - {1'b0, divisor_i};
        q_bit_o    = ~trial[W];
        next_rem_o = (q_bit_o ? trial[W-1:0] : rem_i) << 1;
    end
endmodule

// File: rtl/float_divider_seq.sv
// float_divider_seq: iterative IEEE-style divider, one quotient bit per clock, RNE rounding
module float_divider_seq import float_pkg::*; #(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int BIAS          = 127
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLOAT_SIZE-1:0] a,
    input  logic [FLOAT_SIZE-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLOAT_SIZE-1:0] out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact,
    output logic                  div_by_zero,
    output logic                  invalid
);
    localparam int N  = MANTISSA_SIZE + 3;
    localparam int CW = $clog2(N);
    localparam int EW = EXPONENT_SIZE + 2;
    localparam int M  = MANTISSA_SIZE;
    localparam logic [FLOAT_SIZE-1:0]    QNAN  = FLOAT_SIZE'(qnan(EXPONENT_SIZE, MANTISSA_SIZE));
    localparam logic [EXPONENT_SIZE-1:0] EONES = '1;

    state_t                   state_q, state_d;
    cls_t                     ca_q, ca_d, cb_q, cb_d, cls_a, cls_b;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     sign_q, sign_d;
    logic [EXPONENT_SIZE-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [M:0]               div_q, div_d;
    logic [M+1:0]             rem_q, rem_d, step_rem;
    logic [N-1:0]             q_q, q_d;
    logic [FLOAT_SIZE-1:0]    out_q, out_d, sp_out, rn_out;
    logic [4:0]               flags_q, flags_d, sp_flags, rn_flags;
    logic                     step_q, norm, guard, sticky, inc, carry, ovf, unf, nan_case, inf_case;
    logic [M:0]               frac_g;
    logic [M-1:0]             frac_r;
    logic [EW-1:0]            e_u;

    float_div_step #(.W(M + 2)) u_step (
        .rem_i     (rem_q),
        .divisor_i ({1'b0, div_q}),
        .next_rem_o(step_rem),
        .q_bit_o   (step_q)
    );

    assign cls_a = classify(a[FLOAT_SIZE-2 -: EXPONENT_SIZE] == '0, &a[FLOAT_SIZE-2 -: EXPONENT_SIZE], |a[M-1:0]);
    assign cls_b = classify(b[FLOAT_SIZE-2 -: EXPONENT_SIZE] == '0, &b[FLOAT_SIZE-2 -: EXPONENT_SIZE], |b[M-1:0]);
    assign in_ready    = state_q == IDLE;
    assign out_valid   = state_q == DONE;
    assign out         = out_q;
    assign {overflow, underflow, inexact, div_by_zero, invalid} = flags_q;

    // Special-operand result and normalise/round/range result of the finished recurrence.
    always_comb begin
        nan_case = ca_q == NAN || cb_q == NAN || (ca_q == ZERO && cb_q == ZERO) || (ca_q == INF && cb_q == INF);
        inf_case = ca_q == INF || cb_q == ZERO;
        sp_out   = nan_case ? QNAN : inf_case ? {sign_q, EONES, M'(0)} : {sign_q, (FLOAT_SIZE-1)'(0)};
        sp_flags = {3'b000, !nan_case && ca_q == NORM && cb_q == ZERO, nan_case};
        norm     = ~q_q[N-1];
        frac_g   = norm ? q_q[N-3:0] : q_q[N-2:1];
        guard    = frac_g[0];
        sticky   = (~norm & q_q[0]) | (|rem_q);
        inc      = guard & (sticky | frac_g[1]);
        {carry, frac_r} = {1'b0, frac_g[M:1]} + (M+1)'(inc);
        e_u      = EW'(ea_q) - EW'(eb_q) + EW'(BIAS) - EW'(norm) + EW'(carry);
        ovf      = !e_u[EW-1] && e_u >= EW'((1 << EXPONENT_SIZE) - 1);
        unf      = e_u[EW-1] || e_u == '0;
        rn_out   = ovf ? {sign_q, EONES, M'(0)} : unf ? {sign_q, (FLOAT_SIZE-1)'(0)} : {sign_q, e_u[EXPONENT_SIZE-1:0], frac_r};
        rn_flags = {ovf, unf, guard | sticky | ovf | unf, 2'b00};
    end

    // Next-state logic: hold everything by default, update per state.
    always_comb begin
        state_d = state_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        div_d   = div_q;
        rem_d   = rem_q;
        q_d     = q_q;
        out_d   = out_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: if (in_valid) begin
                ca_d    = cls_a;
                cb_d    = cls_b;
                sign_d  = a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
                ea_d    = a[FLOAT_SIZE-2 -: EXPONENT_SIZE];
                eb_d    = b[FLOAT_SIZE-2 -: EXPONENT_SIZE];
                div_d   = {1'b1, b[M-1:0]};
                rem_d   = {2'b01, a[M-1:0]};
                q_d     = '0;
                cnt_d   = CW'(N - 1);
                state_d = (cls_a == NORM && cls_b == NORM) ? DIVIDE : SPECIAL;
            end
            SPECIAL: begin
                out_d   = sp_out;
                flags_d = sp_flags;
                state_d = DONE;
            end
            DIVIDE: begin
                rem_d   = step_rem;
                q_d     = {q_q[N-2:0], step_q};
                cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
                state_d = cnt_q == '0 ? ROUND : DIVIDE;
            end
            ROUND: begin
                out_d   = rn_out;
                flags_d = rn_flags;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ca_q    <= ZERO;
            cb_q    <= ZERO;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_float_divider_seq.sv
// tb_float_divider_seq: directed vector table plus handshake-hold and reset-abort sequences
module tb_float_divider_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, overflow, underflow, inexact, div_by_zero, invalid;
    logic [31:0] out;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
    } vec_t;
    vec_t vecs[15];

    float_divider_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .overflow   (overflow),
        .underflow  (underflow),
        .inexact    (inexact),
        .div_by_zero(div_by_zero),
        .invalid    (invalid)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {overflow, underflow, inexact, div_by_zero, invalid};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Issue one operation and measure accept-edge-to-out_valid latency (accept edge counts as 1).
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb, output logic [31:0] ro,
                         output logic [4:0] rf, output int lat);
        @(negedge clk);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ro = out;
        rf = flags();
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ro, hold_o;
        logic [4:0]  rf, hold_f;
        int          lat;
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28};
        vecs[1]  = '{32'h3FF80000, 32'h3F800000, 32'h3FF80000, 5'b00000, 28};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00100, 28};
        vecs[3]  = '{32'h40C00000, 32'h00000000, 32'h7F800000, 5'b00010, 2};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b00001, 2};
        vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b00001, 2};
        vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b10100, 28};
        vecs[7]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 5'b01100, 28};
        vecs[8]  = '{32'hC0000000, 32'h40000000, 32'hBF800000, 5'b00000, 28};
        vecs[9]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00001, 2};
        vecs[10] = '{32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 2};
        vecs[11] = '{32'h40000000, 32'h7F800000, 32'h00000000, 5'b00000, 2};
        vecs[12] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 2};
        vecs[13] = '{32'h3F800000, 32'h40E00000, 32'h3E124925, 5'b00100, 28};
        vecs[14] = '{32'h3FC00000, 32'h3FA00000, 32'h3F99999A, 5'b00100, 28};

        // Reset with a stray in_valid that must be ignored.
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out", out, 32'h0);
        chk("reset flags", 32'(flags()), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        chk("post-reset out_valid", 32'(out_valid), 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, ro, rf, lat);
            chk($sformatf("v%0d out", i), ro, vecs[i].q);
            chk($sformatf("v%0d flags", i), 32'(rf), 32'(vecs[i].f));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            release_out();
            chk($sformatf("v%0d in_ready after release", i), 32'(in_ready), 32'd1);
        end

        // Hold out_ready low for 10 cycles while a new request is offered.
        issue(32'h3F800000, 32'h40400000, hold_o, hold_f, lat);
        chk("hold out", hold_o, 32'h3EAAAAAB);
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h40C00000;
        b = 32'h00000000;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d out", k), out, hold_o);
            chk($sformatf("hold%0d flags", k), 32'(flags()), 32'(hold_f));
            chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        chk("hold release in_ready", 32'(in_ready), 32'd1);
        chk("hold release out_valid", 32'(out_valid), 32'd0);

        // Abort an operation mid-iteration with reset.
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort out", out, 32'h0);
        chk("abort flags", 32'(flags()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(32'h3F800000, 32'h3F800000, ro, rf, lat);
        chk("after abort out", ro, 32'h3F800000);
        chk("after abort flags", 32'(rf), 32'd0);
        chk("after abort latency", 32'(lat), 32'd28);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/float_divider_seq.md
# float_divider_seq

Iterative, parameterised IEEE-754-style floating-point divider with valid/ready handshakes on input and output. It computes one quotient bit per clock with a restoring radix-2 recurrence and rounds to nearest-even. It handles zero, infinity and NaN operands and reports five exception flags. It is the multi-cycle, area-lean successor to the combinational float divider and sits behind the FPU operand issue stage.

## Interface
- FLOAT_SIZE, 32: total float width.
- EXPONENT_SIZE, 8: exponent field width.
- MANTISSA_SIZE, 23: stored fraction width (hidden bit excluded).
- BIAS, 127: exponent bias.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  divider can accept operands; high only in IDLE.
- a  input  FLOAT_SIZE  dividend.
- b  input  FLOAT_SIZE  divisor.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- out  output  FLOAT_SIZE  quotient a/b.
- overflow, underflow, inexact, div_by_zero, invalid  output  1 each  exception flags, qualified by out_valid.

## Operation
- States:
  - IDLE: in_ready=1. On accept (in_valid&in_ready), latch and classify the operands, then go to SPECIAL or DIVIDE.
  - SPECIAL: result fixed by the operand classes; go to DONE next cycle.
  - DIVIDE: N=MANTISSA_SIZE+3 iterations, counter counts down to 0, then go to ROUND.
  - ROUND: normalise, round, check range; go to DONE.
  - DONE: out_valid=1; on out_ready go to IDLE.
- Operand classes:
  - exp==0 is zero; subnormals are flushed to signed zero with no flag.
  - exp all-ones with fraction 0 is inf; exp all-ones with fraction nonzero is NaN.
- Special results (sign = sign_a^sign_b unless NaN):
  - Any NaN, 0/0 or inf/inf: canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0), invalid=1.
  - finite-nonzero/0: ±inf, div_by_zero=1.
  - inf/finite: ±inf, no flags.
  - 0/nonzero and finite/inf: ±0, no flags.
- Recurrence:
  - Remainder width MANTISSA_SIZE+2, initialised to {1,ma}. Divisor is {1,mb}.
  - Each step: trial = rem - divisor. If trial≥0, q bit=1 and rem=trial<<1; else q bit=0 and rem<<=1.
  - N steps give quotient bits of weight 2^0 down to 2^-(M+2). Sticky = (final rem != 0).
- Normalise: if q[N-1]==0, shift q left 1 and decrement the exponent. This leaves 1 hidden bit, M fraction bits, a guard bit, and sticky (the shifted-out low bit ORs into sticky).
- Round to nearest-even: increment when guard & (sticky | lsb). inexact = guard|sticky. A carry out of the fraction gives fraction 0 and exponent +1.
- Exponent arithmetic, signed EXPONENT_SIZE+2 bits: e = ea − eb + BIAS − norm + carry.
  - e ≥ 2^EXPONENT_SIZE−1: ±inf, overflow=1, inexact=1.
  - e ≤ 0: ±0, underflow=1, inexact=1.
- Only one operation is in flight at a time.

## Timing
- Reset: state IDLE. out, out_valid and all flags are 0. Counter is 0. in_ready=1 from the first cycle after reset_n is sampled low then high.
- reset_n low mid-operation aborts the operation with no output. An in_valid in a reset cycle is ignored.
- Latency, counted from the accept edge to out_valid high:
  - Normal path: N+2 cycles (28 for the 32-bit parameters).
  - Special path: 2 cycles.
- out and the flags are registered and stay stable throughout DONE, however long out_ready is held low.
- in_ready is low from the accept until the cycle after the output handshake. There is no same-cycle output/input turnaround, so a back-to-back initiation interval is N+3.
- in_valid while busy is ignored; the producer must hold its operands.

## Structure
- Package float_pkg holds:
  - state enum (IDLE, SPECIAL, DIVIDE, ROUND, DONE);
  - operand-class enum (ZERO, NORM, INF, NAN);
  - a classify function;
  - a canonical-qNaN constant function parameterised by the field widths.
- One sub-module, float_div_step: combinational single restoring step, taking rem and divisor and producing next_rem and q_bit.
- The top level holds the FSM, the counter, the operand and quotient registers, and the round/range logic.

## Test plan
- 0x3F800000/0x3F800000 → out=0x3F800000, no flags, out_valid exactly 28 cycles after accept; 0x3FF80000/0x3F800000 → 0x3FF80000.
- 0x3F800000/0x40400000 (1/3) → out=0x3EAAAAAB, inexact=1 (round-up path).
- 0x40C00000/0x00000000 → 0x7F800000, div_by_zero=1. 0/0 → 0x7FC00000, invalid=1. 0x7F800000/0x7F800000 → 0x7FC00000, invalid=1. All with latency 2.
- 0x7F000000/0x3E800000 → 0x7F800000, overflow=1, inexact=1. 0x00800000/0x7F000000 → 0x00000000, underflow=1, inexact=1.
- Hold out_ready=0 for 10 cycles: out and flags stable, in_ready=0, a new in_valid is ignored. Release: in_ready=1 on the next cycle.
- Pulse reset_n low during DIVIDE iteration 10: next cycle state is IDLE with out_valid=0 and all outputs 0. A fresh 1/1 then completes correctly in 28 cycles.
